// File: rtl/vta_fetch_pkg.sv
// Shared constants and state type for the instruction-fetch burst sequencer.
package vta_fetch_pkg;

    localparam int         INSN_BYTES     = 16;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [2:0] AXI_SIZE_16B   = 3'b100;
    localparam logic [1:0] RESP_OKAY      = 2'b00;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ADDR  = 2'd1,
        ST_DATA  = 2'd2,
        ST_DRAIN = 2'd3
    } fetch_state_t;

    // Beats left before the next 4 KB page, always 1..256.
    function automatic logic [8:0] beats_to_4k(input logic [11:0] offs);
        logic [12:0] bytes_left;
        bytes_left = 13'd4096 - {1'b0, offs};
        return bytes_left[12:4];
    endfunction

endpackage

// File: rtl/insn_fetch_ctrl_if.sv
// AXI4 read-address/read-data channels plus the AXI-Stream instruction output.
interface insn_fetch_ctrl_if #(
    parameter int DATA_W = 128,
    parameter int ADDR_W = 32
);
    logic [ADDR_W-1:0] m_axi_ins_port_ARADDR;
    logic [7:0]        m_axi_ins_port_ARLEN;
    logic [2:0]        m_axi_ins_port_ARSIZE;
    logic [1:0]        m_axi_ins_port_ARBURST;
    logic              m_axi_ins_port_ARVALID;
    logic              m_axi_ins_port_ARREADY;
    logic [DATA_W-1:0] m_axi_ins_port_RDATA;
    logic [1:0]        m_axi_ins_port_RRESP;
    logic              m_axi_ins_port_RLAST;
    logic              m_axi_ins_port_RVALID;
    logic              m_axi_ins_port_RREADY;
    logic [DATA_W-1:0] insn_TDATA;
    logic              insn_TVALID;
    logic              insn_TREADY;

    modport master (
        output m_axi_ins_port_ARADDR, m_axi_ins_port_ARLEN, m_axi_ins_port_ARSIZE,
               m_axi_ins_port_ARBURST, m_axi_ins_port_ARVALID, m_axi_ins_port_RREADY,
               insn_TDATA, insn_TVALID,
        input  m_axi_ins_port_ARREADY, m_axi_ins_port_RDATA, m_axi_ins_port_RRESP,
               m_axi_ins_port_RLAST, m_axi_ins_port_RVALID, insn_TREADY
    );

    modport slave (
        input  m_axi_ins_port_ARADDR, m_axi_ins_port_ARLEN, m_axi_ins_port_ARSIZE,
               m_axi_ins_port_ARBURST, m_axi_ins_port_ARVALID, m_axi_ins_port_RREADY,
               insn_TDATA, insn_TVALID,
        output m_axi_ins_port_ARREADY, m_axi_ins_port_RDATA, m_axi_ins_port_RRESP,
               m_axi_ins_port_RLAST, m_axi_ins_port_RVALID, insn_TREADY
    );
endinterface

// File: rtl/insn_skid_buf.sv
// Two-entry registered skid buffer between the R channel and the instruction stream.
module insn_skid_buf #(
    parameter int DATA_W = 128
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              has_space,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic              empty
);
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              skid_valid_q, skid_valid_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;
    logic              push, pop;

    assign has_space = !skid_valid_q;
    assign push      = in_valid && has_space;
    assign pop       = out_valid_q && out_ready;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign empty     = !out_valid_q && !skid_valid_q;

    always_comb begin
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        if (!out_valid_q || pop) begin
            // Skid entry is older than anything arriving, so it moves out first.
            if (skid_valid_q) begin
                out_data_d   = skid_data_q;
                out_valid_d  = 1'b1;
                skid_valid_d = 1'b0;
            end else if (push) begin
                out_data_d  = in_data;
                out_valid_d = 1'b1;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (push) begin
            skid_data_d  = in_data;
            skid_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
        end
    end

endmodule

// File: rtl/insn_fetch_ctrl.sv
// Instruction-fetch burst sequencer: splits a fetch command into AXI4 INCR bursts
// and forwards returned beats in order onto the instruction stream.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | waiting for start
// ST_ADDR  | presenting one AR burst (held one cycle after a previous burst)
// ST_DATA  | accepting R beats of the single outstanding burst
// ST_DRAIN | all beats received, waiting for the skid buffer to empty
module insn_fetch_ctrl
    import vta_fetch_pkg::*;
#(
    parameter int DATA_W    = 128,
    parameter int ADDR_W    = 32,
    parameter int MAX_BURST = 16
) (
    input  logic              ap_clk,
    input  logic              ap_rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] insn_base,
    input  logic [31:0]       insn_count,
    output logic              busy,
    output logic              done,
    output logic              err,
    insn_fetch_ctrl_if.master bus
);
    localparam logic [8:0] MAX_BEATS = 9'(MAX_BURST);

    fetch_state_t      state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       remaining_q, remaining_d;
    logic [8:0]        beat_cnt_q, beat_cnt_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              gap_q, gap_d;
    logic [8:0]        beats;
    logic              ar_valid, ar_hs, r_ready, r_hs;
    logic              buf_space, buf_empty;

    always_comb begin
        beats = beats_to_4k(addr_q[11:0]);
        if (beats > MAX_BEATS) beats = MAX_BEATS;
        if ({23'd0, beats} > remaining_q) beats = remaining_q[8:0];
    end

    assign ar_valid = (state_q == ST_ADDR) && !gap_q;
    assign ar_hs    = ar_valid && bus.m_axi_ins_port_ARREADY;
    assign r_ready  = (state_q == ST_DATA) && buf_space;
    assign r_hs     = r_ready && bus.m_axi_ins_port_RVALID;

    assign bus.m_axi_ins_port_ARADDR  = addr_q;
    assign bus.m_axi_ins_port_ARLEN   = (state_q == ST_ADDR) ? 8'(beats - 9'd1) : 8'd0;
    assign bus.m_axi_ins_port_ARSIZE  = AXI_SIZE_16B;
    assign bus.m_axi_ins_port_ARBURST = AXI_BURST_INCR;
    assign bus.m_axi_ins_port_ARVALID = ar_valid;
    assign bus.m_axi_ins_port_RREADY  = r_ready;

    assign busy = busy_q;
    assign done = done_q;
    assign err  = err_q;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        remaining_d = remaining_q;
        beat_cnt_d  = beat_cnt_q;
        busy_d      = busy_q;
        err_d       = err_q;
        done_d      = 1'b0;
        gap_d       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    addr_d      = {insn_base[ADDR_W-1:4], 4'b0};
                    remaining_d = insn_count;
                    err_d       = 1'b0;
                    busy_d      = 1'b1;
                    state_d     = (insn_count == 32'd0) ? ST_DRAIN : ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (ar_hs) begin
                    beat_cnt_d = beats;
                    state_d    = ST_DATA;
                end
            end
            ST_DATA: begin
                if (r_hs) begin
                    beat_cnt_d = beat_cnt_q - 9'd1;
                    if (remaining_q != 32'd0) remaining_d = remaining_q - 32'd1;
                    addr_d = addr_q + ADDR_W'(INSN_BYTES);
                    // RLAST is only checked; beat_cnt alone decides where the burst ends.
                    if ((bus.m_axi_ins_port_RRESP != RESP_OKAY) ||
                        (bus.m_axi_ins_port_RLAST != (beat_cnt_q == 9'd1)))
                        err_d = 1'b1;
                    if (beat_cnt_q == 9'd1) begin
                        if (remaining_q > 32'd1) begin
                            state_d = ST_ADDR;
                            gap_d   = 1'b1;
                        end else begin
                            state_d = ST_DRAIN;
                        end
                    end
                end
            end
            ST_DRAIN: begin
                if (buf_empty) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            remaining_q <= '0;
            beat_cnt_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            gap_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
            beat_cnt_q  <= beat_cnt_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            gap_q       <= gap_d;
        end
    end

    insn_skid_buf #(.DATA_W(DATA_W)) u_skid (
        .clk       (ap_clk),
        .rst_n     (ap_rst_n),
        .in_valid  (r_hs),
        .in_data   (bus.m_axi_ins_port_RDATA),
        .has_space (buf_space),
        .out_valid (bus.insn_TVALID),
        .out_data  (bus.insn_TDATA),
        .out_ready (bus.insn_TREADY),
        .empty     (buf_empty)
    );

endmodule

// File: tb/tb_insn_fetch_ctrl.sv
// Bench for insn_fetch_ctrl: memory responder, command-level reference model and per-cycle checker.
module tb_insn_fetch_ctrl;
    logic        ap_clk = 1'b0;
    logic        ap_rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] insn_base = '0;
    logic [31:0] insn_count = '0;
    logic        busy, done, err;

    insn_fetch_ctrl_if #(.DATA_W(128), .ADDR_W(32)) bus ();

    insn_fetch_ctrl #(.DATA_W(128), .ADDR_W(32), .MAX_BURST(16)) dut (
        .ap_clk     (ap_clk),
        .ap_rst_n   (ap_rst_n),
        .start      (start),
        .insn_base  (insn_base),
        .insn_count (insn_count),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .bus        (bus)
    );

    always #5 ap_clk = ~ap_clk;

    typedef struct {
        logic [31:0] addr;
        logic        last;
    } mbeat_t;

    int n_cmp = 0;
    int n_fail = 0;

    logic [39:0]  exp_ar_q[$];
    logic [127:0] exp_beat_q[$];
    mbeat_t       mem_q[$];
    int           mem_idx = 0;
    logic [31:0]  salt = 32'h0100_0000;
    int           inj_resp_idx = -1;
    int           inj_last_idx = -1;
    bit           tready_rand = 0, rvalid_gap = 0, ar_rand = 0;

    longint       cyc = 0, done_at = 0, busy_from = 0, start_cyc = 0, done_cyc = 0;
    bit           exp_err = 0;
    bit           r_hs_prev = 0, t_stall_prev = 0, ar_stall_prev = 0;
    logic [127:0] tdata_prev;
    logic [39:0]  ar_prev;

    int           n_ar = 0, n_out = 0, n_done = 0;
    logic [31:0]  ar_addr_obs[8];
    logic [7:0]   ar_len_obs[8];
    logic [31:0]  first_lo;

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    function automatic logic [127:0] data_of(input logic [31:0] a, input logic [31:0] s);
        return {s, ~a, a ^ 32'h5A5A_C3C3, a};
    endfunction

    // Reference: bursts from min(remaining, 16, beats to page end); beats are consecutive 16 B words.
    function automatic void plan(input logic [31:0] base, input logic [31:0] count);
        logic [31:0] a, rem;
        int b, fk;
        a   = base & 32'hFFFF_FFF0;
        rem = count;
        while (rem != 0) begin
            fk = (4096 - int'(a[11:0])) / 16;
            b  = (rem < 32'd16) ? int'(rem) : 16;
            if (fk < b) b = fk;
            exp_ar_q.push_back({a, 8'(b - 1)});
            a   = a + 32'(16 * b);
            rem = rem - 32'(b);
        end
        a = base & 32'hFFFF_FFF0;
        for (int i = 0; i < int'(count); i++)
            exp_beat_q.push_back(data_of(a + 32'(16 * i), salt));
    endfunction

    // Monitor: compares, then advances the model with what happened at the coming edge.
    initial begin
        mbeat_t fb;
        logic [39:0] ea;
        logic bad;
        forever begin
            @(negedge ap_clk);
            if (!ap_rst_n) continue;
            cyc++;
            bad = 1'b0;
            check("busy", busy, (cyc >= busy_from) && (cyc < done_at));
            check("done", done, cyc == done_at);
            check("err", err, exp_err);
            if (done) begin
                n_done++;
                done_cyc = cyc;
            end
            if (r_hs_prev) check("ar_gap", bus.m_axi_ins_port_ARVALID, 1'b0);
            if (ar_stall_prev)
                check("ar_hold", {bus.m_axi_ins_port_ARVALID, bus.m_axi_ins_port_ARADDR,
                                  bus.m_axi_ins_port_ARLEN}, {1'b1, ar_prev});
            if (t_stall_prev)
                check("t_hold", {bus.insn_TVALID, bus.insn_TDATA}, {1'b1, tdata_prev});
            if (bus.m_axi_ins_port_ARVALID)
                check("ar_const", {bus.m_axi_ins_port_ARSIZE, bus.m_axi_ins_port_ARBURST},
                      {3'b100, 2'b01});
            if (bus.m_axi_ins_port_ARVALID && bus.m_axi_ins_port_ARREADY) begin
                check("ar_expected", exp_ar_q.size() != 0, 1'b1);
                if (exp_ar_q.size() != 0) begin
                    ea = exp_ar_q.pop_front();
                    check("ar", {bus.m_axi_ins_port_ARADDR, bus.m_axi_ins_port_ARLEN}, ea);
                end
                if (n_ar < 8) begin
                    ar_addr_obs[n_ar] = bus.m_axi_ins_port_ARADDR;
                    ar_len_obs[n_ar]  = bus.m_axi_ins_port_ARLEN;
                end
                n_ar++;
                for (int i = 0; i <= int'(bus.m_axi_ins_port_ARLEN); i++)
                    mem_q.push_back('{addr: bus.m_axi_ins_port_ARADDR + 32'(16 * i),
                                      last: (i == int'(bus.m_axi_ins_port_ARLEN))});
            end
            if (bus.m_axi_ins_port_RVALID && bus.m_axi_ins_port_RREADY) begin
                check("r_expected", mem_q.size() != 0, 1'b1);
                if (mem_q.size() != 0) begin
                    fb  = mem_q.pop_front();
                    bad = (bus.m_axi_ins_port_RRESP != 2'b00) ||
                          (bus.m_axi_ins_port_RLAST != fb.last);
                end
                mem_idx++;
            end
            if (bus.insn_TVALID && bus.insn_TREADY) begin
                check("t_expected", exp_beat_q.size() != 0, 1'b1);
                if (exp_beat_q.size() != 0) begin
                    check("tdata", bus.insn_TDATA, exp_beat_q.pop_front());
                    if (exp_beat_q.size() == 0) done_at = cyc + 2;
                end
                if (n_out == 0) first_lo = bus.insn_TDATA[31:0];
                n_out++;
            end
            if (start && (cyc >= done_at)) begin
                salt      = salt + 32'h0011_0001;
                plan(insn_base, insn_count);
                exp_err   = 1'b0;
                busy_from = cyc + 1;
                done_at   = (insn_count == 32'd0) ? cyc + 2 : 64'h7FFF_FFFF_FFFF;
                start_cyc = cyc;
                mem_idx   = 0;
                n_ar      = 0;
                n_out     = 0;
                n_done    = 0;
            end
            if (bad) exp_err = 1'b1;
            r_hs_prev     = bus.m_axi_ins_port_RVALID && bus.m_axi_ins_port_RREADY;
            ar_stall_prev = bus.m_axi_ins_port_ARVALID && !bus.m_axi_ins_port_ARREADY;
            ar_prev       = {bus.m_axi_ins_port_ARADDR, bus.m_axi_ins_port_ARLEN};
            t_stall_prev  = bus.insn_TVALID && !bus.insn_TREADY;
            tdata_prev    = bus.insn_TDATA;
        end
    end

    // Memory and consumer: drive slave-side inputs just after each rising edge.
    initial begin
        bus.m_axi_ins_port_ARREADY = 1'b0;
        bus.m_axi_ins_port_RVALID  = 1'b0;
        bus.m_axi_ins_port_RDATA   = '0;
        bus.m_axi_ins_port_RRESP   = 2'b00;
        bus.m_axi_ins_port_RLAST   = 1'b0;
        bus.insn_TREADY            = 1'b0;
        forever begin
            @(posedge ap_clk);
            #1;
            bus.m_axi_ins_port_ARREADY = ar_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.insn_TREADY            = tready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            if (!bus.m_axi_ins_port_RVALID || r_hs_prev) begin
                if (mem_q.size() != 0 && (!rvalid_gap || $urandom_range(0, 1) == 1)) begin
                    bus.m_axi_ins_port_RVALID = 1'b1;
                    bus.m_axi_ins_port_RDATA  = data_of(mem_q[0].addr, salt);
                    bus.m_axi_ins_port_RRESP  = (mem_idx == inj_resp_idx) ? 2'b10 : 2'b00;
                    bus.m_axi_ins_port_RLAST  = mem_q[0].last ^ (mem_idx == inj_last_idx);
                end else begin
                    bus.m_axi_ins_port_RVALID = 1'b0;
                end
            end
        end
    end

    task automatic run_cmd(input logic [31:0] base, input logic [31:0] count);
        int k;
        @(posedge ap_clk); #1;
        start      = 1'b1;
        insn_base  = base;
        insn_count = count;
        @(posedge ap_clk); #1;
        start = 1'b0;
        k = 0;
        while (n_done == 0 && k < 3000) begin
            @(negedge ap_clk);
            k++;
        end
        check("done_seen", n_done != 0, 1'b1);
        repeat (3) @(posedge ap_clk);
        #1;
        check("ar_left", exp_ar_q.size(), 0);
        check("beats_left", exp_beat_q.size(), 0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge ap_clk);
        @(negedge ap_clk);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_err", err, 1'b0);
        check("rst_arvalid", bus.m_axi_ins_port_ARVALID, 1'b0);
        check("rst_araddr", bus.m_axi_ins_port_ARADDR, 32'd0);
        check("rst_arlen", bus.m_axi_ins_port_ARLEN, 8'd0);
        check("rst_rready", bus.m_axi_ins_port_RREADY, 1'b0);
        check("rst_tvalid", bus.insn_TVALID, 1'b0);
        check("rst_tdata", bus.insn_TDATA, 128'd0);
        @(posedge ap_clk); #1;
        ap_rst_n = 1'b1;

        run_cmd(32'h0000_1000, 32'd5);
        check("c1_nar", n_ar, 1);
        check("c1_ar0", {ar_addr_obs[0], ar_len_obs[0]}, {32'h0000_1000, 8'd4});
        check("c1_nout", n_out, 5);
        check("c1_first", first_lo, 32'h0000_1000);
        check("c1_err", err, 1'b0);

        run_cmd(32'h0000_1000, 32'd20);
        check("c2_nar", n_ar, 2);
        check("c2_ar0", {ar_addr_obs[0], ar_len_obs[0]}, {32'h0000_1000, 8'd15});
        check("c2_ar1", {ar_addr_obs[1], ar_len_obs[1]}, {32'h0000_1100, 8'd3});
        check("c2_nout", n_out, 20);

        run_cmd(32'h0000_1FC0, 32'd8);
        check("c3_ar0", {ar_addr_obs[0], ar_len_obs[0]}, {32'h0000_1FC0, 8'd3});
        check("c3_ar1", {ar_addr_obs[1], ar_len_obs[1]}, {32'h0000_2000, 8'd3});

        run_cmd(32'h0000_2FF9, 32'd3);
        check("c4_ar0", {ar_addr_obs[0], ar_len_obs[0]}, {32'h0000_2FF0, 8'd0});
        check("c4_ar1", {ar_addr_obs[1], ar_len_obs[1]}, {32'h0000_3000, 8'd1});

        run_cmd(32'hFFFF_FFE0, 32'd4);
        check("c5_ar0", {ar_addr_obs[0], ar_len_obs[0]}, {32'hFFFF_FFE0, 8'd1});
        check("c5_ar1", {ar_addr_obs[1], ar_len_obs[1]}, {32'h0000_0000, 8'd1});

        tready_rand = 1; rvalid_gap = 1; ar_rand = 1;
        run_cmd(32'h0000_4F80, 32'd16);
        check("c6_nout", n_out, 16);
        check("c6_ar0", {ar_addr_obs[0], ar_len_obs[0]}, {32'h0000_4F80, 8'd7});
        check("c6_ar1", {ar_addr_obs[1], ar_len_obs[1]}, {32'h0000_5000, 8'd7});
        tready_rand = 0; rvalid_gap = 0; ar_rand = 0;

        // count 0 followed by a start while still busy
        @(posedge ap_clk); #1;
        start = 1'b1; insn_base = 32'h0000_6000; insn_count = 32'd0;
        @(posedge ap_clk); #1;
        insn_count = 32'd4;
        @(posedge ap_clk); #1;
        start = 1'b0;
        repeat (40) @(posedge ap_clk);
        #1;
        check("c7_ndone", n_done, 1);
        check("c7_nar", n_ar, 0);
        check("c7_lat", done_cyc - start_cyc, 2);

        inj_resp_idx = 1; inj_last_idx = 2;
        run_cmd(32'h0000_8000, 32'd4);
        check("c8_err", err, 1'b1);
        check("c8_nout", n_out, 4);
        inj_resp_idx = -1; inj_last_idx = -1;

        run_cmd(32'h0000_9000, 32'd1);
        check("c9_err_clr", err, 1'b0);

        inj_last_idx = 1;
        run_cmd(32'h0000_A000, 32'd2);
        check("c10_err", err, 1'b1);
        inj_last_idx = -1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/insn_fetch_ctrl.md
# insn_fetch_ctrl

Burst sequencer for the instruction-fetch read port. It takes a start command carrying a DRAM base address and an instruction count, and issues AXI4 read bursts on the `m_axi_ins_port` AR channel. Burst length is limited by the remaining count, MAX_BURST and 4 KB boundaries. Returned 128-bit beats are forwarded in order to a single AXI-Stream instruction output that feeds the opcode dispatcher (load/gemm/store queues).

## Interface
- DATA_W, 128, instruction/beat width in bits
- ADDR_W, 32, AXI address width
- MAX_BURST, 16, maximum beats per AR burst (power of two, ≤256)
- ap_clk  in  1  clock
- ap_rst_n  in  1  asynchronous active-low reset
- start  in  1  single-cycle command strobe
- insn_base  in  ADDR_W  byte address of first instruction (16 B aligned, low 4 bits ignored)
- insn_count  in  32  number of instructions to fetch
- busy  out  1  command in progress
- done  out  1  one-cycle pulse at command completion
- err  out  1  sticky error: non-OKAY RRESP or RLAST mismatch; cleared on accepted start
- m_axi_ins_port_ARADDR  out  ADDR_W  burst start address
- m_axi_ins_port_ARLEN  out  8  beats−1
- m_axi_ins_port_ARSIZE  out  3  constant 3'b100 (16 B)
- m_axi_ins_port_ARBURST  out  2  constant 2'b01 (INCR)
- m_axi_ins_port_ARVALID  out  1  address valid
- m_axi_ins_port_ARREADY  in  1  address ready
- m_axi_ins_port_RDATA  in  DATA_W  read data
- m_axi_ins_port_RRESP  in  2  read response
- m_axi_ins_port_RLAST  in  1  last beat of burst
- m_axi_ins_port_RVALID  in  1  read valid
- m_axi_ins_port_RREADY  out  1  read ready
- insn_TDATA  out  DATA_W  instruction out
- insn_TVALID  out  1  stream valid
- insn_TREADY  in  1  stream ready

## Operation
- States: IDLE, ADDR, DATA, DRAIN.
- IDLE: start accepted only here. On acceptance: latch addr = {insn_base[ADDR_W-1:4],4'b0}, latch remaining = insn_count, clear err, assert busy. If insn_count==0, go directly to DRAIN; otherwise go to ADDR. A start seen in any other state is ignored.
- ADDR: compute beats = min(remaining, MAX_BURST, (4096 − addr[11:0]) >> 4). Drive ARADDR=addr, ARLEN=beats−1, ARVALID=1. Hold all three stable until ARREADY. On handshake, load beat_cnt=beats and go to DATA.
- DATA: RREADY = skid buffer has a free entry. On each R handshake:
  - push RDATA into the skid buffer;
  - decrement beat_cnt and remaining;
  - advance addr by 16.
- DATA exit on the final beat of the burst (beat_cnt==1): go to ADDR if remaining>0, otherwise to DRAIN.
- Only one burst is outstanding at a time.
- Error checks on every R handshake:
  - RRESP≠0 sets err; the data is still forwarded.
  - RLAST asserted when beat_cnt≠1, or deasserted when beat_cnt==1, sets err.
  - Beat counting uses beat_cnt only; RLAST never alters control flow.
- DRAIN: wait until the skid buffer is empty, then pulse done for one cycle, deassert busy, return to IDLE.
- Arithmetic: remaining is 32-bit unsigned and never underflows. addr wraps modulo 2^ADDR_W. The 4 KB term is in the range 1..256.

## Timing
- Reset values: busy=0, done=0, err=0, ARVALID=0, ARADDR=0, ARLEN=0, RREADY=0, insn_TVALID=0, insn_TDATA=0. State returns to IDLE and the skid buffer is emptied.
- Reset asserted mid-burst aborts immediately. No drain, and no attempt to consume outstanding R beats.
- start at cycle t → ARVALID high at t+1.
- R handshake at cycle t → that beat appears on insn_TVALID/TDATA at t+1 (registered output).
- Sustains 1 beat/cycle with TREADY held high.
- Backpressure: with the buffer full, RREADY=0 in the same cycle. No beat is lost or duplicated under any TREADY pattern.
- Output stream rules: TVALID, once high, stays high until TREADY; TDATA stays stable while TVALID && !TREADY.
- done rises in the cycle after the last beat leaves the buffer. For insn_count==0, done rises at t+2 after start, with no AR issued.
- Consecutive bursts: minimum 1 idle cycle between the last R beat and the next ARVALID.

## Structure
- Shared package `vta_fetch_pkg`: INSN_BYTES=16, AXI_BURST_INCR, AXI_SIZE_16B, RESP_OKAY, and the state enum `fetch_state_t`.
- One sub-module, `insn_skid_buf`: 2-entry registered skid buffer with AXI-Stream in/out and a `has_space` output. It provides the registered TDATA/TVALID and drives RREADY.
- Top-level file contains the FSM, address/count datapath and burst-length computation.

## Test plan
- base 0x1000, count 5 → one AR: ARADDR=0x1000, ARLEN=4; 5 beats out in order; done pulse; err=0.
- base 0x1000, count 20 → two ARs: (0x1000, ARLEN=15) then (0x1100, ARLEN=3); 20 beats in order.
- base 0x1FC0, count 8 → 4 KB split: (0x1FC0, ARLEN=3) then (0x2000, ARLEN=3).
- count 16 with insn_TREADY driven by a random 50% pattern and RVALID gapped → all 16 RDATA values out in order, none dropped or repeated; TDATA stable while stalled.
- count 0 → no ARVALID ever; done high exactly once, 2 cycles after start; second start while busy (count 4) ignored.
- count 4, RRESP=2'b10 on beat 2, and RLAST early on beat 3 → err=1 after beat 2; all 4 beats forwarded; err cleared by next start.
